// File: rtl/philv_fetch_unit_pkg.sv
// Shared definitions for the PhilosophyV fetch unit: FSM encodings, PC step and alignment.
package philv_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int FETCH_PC_INCR = 4;
  localparam int PC_ALIGN_LSBS = 2;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/philv_sync_fifo.sv
// Synchronous FIFO with flush; rdata shows the head word combinationally (no bypass).
module philv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/philv_fetch_unit.sv
// PhilosophyV instruction fetch: PC, credit-limited imem requests, prefetch FIFO to decode.
// Optional perf counters are enabled by defining PHILV_FETCH_PERF_EN.
module philv_fetch_unit
  import philv_fetch_unit_pkg::*;
#(
  parameter int                   BUS_WIDTH        = 32,
  parameter int                   FIFO_DEPTH       = 4,
  parameter int                   MAX_OUTSTANDING  = 2,
  parameter logic [BUS_WIDTH-1:0] PC_START_ADDRESS = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [BUS_WIDTH-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [BUS_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  output logic                 instr_valid,
  output logic [BUS_WIDTH-1:0] instr,
  output logic [BUS_WIDTH-1:0] instr_pc,
  input  logic                 instr_ready
`ifdef PHILV_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int OUT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [BUS_WIDTH-1:0] PC_ALIGN_MASK = ~BUS_WIDTH'((1 << PC_ALIGN_LSBS) - 1);

  fetch_state_e           state;
  fetch_state_e           state_d;
  logic [BUS_WIDTH-1:0]   pc;
  logic [BUS_WIDTH-1:0]   pc_d;
  logic [OUT_W-1:0]       outstanding;
  logic [OUT_W-1:0]       out_d;

  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [2*BUS_WIDTH-1:0] fifo_rdata;
  logic [BUS_WIDTH-1:0]   tag_pc;
  logic [OUT_W-1:0]       tag_count;
  logic                   tag_full;
  logic                   tag_empty;

  logic credit_ok;
  logic issue;
  logic rsp;
  logic keep_rsp;
  logic tag_pop;
  logic pop;

  // Request/response bookkeeping; instr_ready feeds only the FIFO pop, never the request.
  always_comb begin
    credit_ok = (int'(fifo_count) + int'(outstanding) < FIFO_DEPTH) &&
                (int'(outstanding) < MAX_OUTSTANDING);
    imem_req  = (state == ST_FETCH) && !redirect_valid && credit_ok;
    imem_addr = pc;
    issue     = imem_req && imem_gnt;
    rsp       = imem_rvalid && (outstanding != '0);
    keep_rsp  = rsp && (state == ST_FETCH) && !redirect_valid;
    tag_pop   = rsp && (state == ST_FETCH);
    pop       = instr_valid && instr_ready;
    out_d     = outstanding + OUT_W'(issue) - OUT_W'(rsp);
  end

  always_comb begin
    pc_d    = pc;
    state_d = state;
    if (issue) pc_d = pc + BUS_WIDTH'(FETCH_PC_INCR);
    case (state)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
      ST_DRAIN: state_d = (out_d == '0) ? ST_FETCH : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d    = redirect_pc & PC_ALIGN_MASK;
      state_d = (out_d != '0) ? ST_DRAIN : ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= PC_START_ADDRESS;
      outstanding <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      outstanding <= out_d;
    end
  end

  philv_sync_fifo #(
    .WIDTH (2 * BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk   (clk),
    .rst   (rst),
    .push  (keep_rsp),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({imem_rdata, tag_pc}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue-order PCs of requests in flight; head tags the next response.
  philv_sync_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (tag_pop),
    .flush (redirect_valid),
    .wdata (pc),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign instr_valid       = !fifo_empty;
  assign {instr, instr_pc} = fifo_rdata;

  // Credit accounting must keep both queues from over/underflowing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(keep_rsp && fifo_full));
      assert (!(issue && tag_full));
      assert (!(tag_pop && tag_empty));
      assert (state != ST_FETCH || tag_count == outstanding);
    end
  end

`ifdef PHILV_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= sat_inc(perf_fetched);
      if (state == ST_FETCH && !instr_valid) perf_stall <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_philv_fetch_unit.sv
// Directed bench for philv_fetch_unit with an imem responder and an {instr,pc} scoreboard.
module tb_philv_fetch_unit;

  localparam int BW      = 32;
  localparam int RSP_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [BW-1:0] redirect_pc;
  logic          imem_req;
  logic [BW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [BW-1:0] imem_rdata;
  logic          instr_valid;
  logic [BW-1:0] instr;
  logic [BW-1:0] instr_pc;
  logic          instr_ready;
`ifdef PHILV_FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;
`endif

  typedef struct {
    logic [BW-1:0] addr;
    int            t;
  } pend_t;

  typedef struct {
    logic [BW-1:0] instr;
    logic [BW-1:0] pc;
  } exp_t;

  pend_t pend[$];
  exp_t  exp_q[$];

  int n_err     = 0;
  int n_checks  = 0;
  int n_pops    = 0;
  int cyc       = 0;
  int stale_cnt = 0;
  bit gnt_on    = 1'b0;
  bit rsp_on    = 1'b1;

  always #5 clk = ~clk;

  philv_fetch_unit #(
    .BUS_WIDTH        (BW),
    .FIFO_DEPTH       (4),
    .MAX_OUTSTANDING  (2),
    .PC_START_ADDRESS (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef PHILV_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Instruction memory: records grants, answers in order RSP_LAT cycles later with ~addr.
  // Responses still owed when a redirect lands are stale and expected to be dropped.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pend.delete();
        exp_q.delete();
        stale_cnt = 0;
      end else begin
        if (imem_rvalid && pend.size() > 0) begin
          void'(pend.pop_front());
          if (stale_cnt > 0) stale_cnt--;
        end
        if (redirect_valid) begin
          exp_q.delete();
          stale_cnt = pend.size();
        end
        if (imem_req && imem_gnt) pend.push_back('{addr: imem_addr, t: cyc});
      end
      cyc++;
      #1;
      imem_gnt    = gnt_on;
      imem_rvalid = 1'b0;
      if (!rst && rsp_on && pend.size() > 0 && pend[0].t + RSP_LAT <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~pend[0].addr;
        if (stale_cnt == 0) exp_q.push_back('{instr: ~pend[0].addr, pc: pend[0].addr});
      end
    end
  end

  // Decode side: every handshake must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
        chk("sb_has_entry", BW'(exp_q.size() != 0), BW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, e.instr);
          n_pops++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_req", BW'(imem_req), BW'(0));
    chk("rst_valid", BW'(instr_valid), BW'(0));
    step(1);
    rst = 1'b0;
    step(1);

    // Grant withheld: request and address must hold.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", BW'(imem_req), BW'(1));
      chk("stall_addr", imem_addr, 32'h0);
    end

    // Back-to-back streaming.
    step(1);
    gnt_on      = 1'b1;
    instr_ready = 1'b1;
    step(14);

    // Reset in the middle of traffic.
    rst = 1'b1;
    step(2);
    @(negedge clk);
    chk("rst_mid_req", BW'(imem_req), BW'(0));
    chk("rst_mid_valid", BW'(instr_valid), BW'(0));
    step(1);
    rst         = 1'b0;
    instr_ready = 1'b0;

    // Decode stalled: FIFO fills and requests stop.
    step(14);
    @(negedge clk);
    chk("full_req_drop", BW'(imem_req), BW'(0));
    chk("full_valid", BW'(instr_valid), BW'(1));
    chk("full_head_pc", instr_pc, 32'h0);
    chk("full_head_instr", instr, 32'hFFFF_FFFF);
    step(3);
    @(negedge clk);
    chk("head_stable_pc", instr_pc, 32'h0);
    step(1);
    instr_ready = 1'b1;
    step(10);

    // Two requests in flight, then redirect to an unaligned target.
    rsp_on = 1'b0;
    step(8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    rsp_on         = 1'b1;
    @(negedge clk);
    chk("redir_req", BW'(imem_req), BW'(0));
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("drain_req", BW'(imem_req), BW'(0));
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) ok = 1'b1;
    end
    chk("drain_exit", BW'(ok), BW'(1));
    chk("drain_addr", imem_addr, 32'h0000_0100);
    step(8);

    // Redirect colliding with a response and a pop; target exercises PC wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clk);
    chk("redir2_valid", BW'(instr_valid), BW'(1));
    chk("redir2_req", BW'(imem_req), BW'(0));
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty", BW'(instr_valid), BW'(0));
    chk("wrap_req", BW'(imem_req), BW'(1));
    chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step(8);

    chk("pop_count_min", BW'(n_pops >= 25), BW'(1));
    instr_ready = 1'b0;
    gnt_on      = 1'b0;
    step(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
